alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_pkg.sv | 51 +++++
 rtl/alu_compute.sv | 65 ++++++
 rtl/alu_pipe.sv | 121 ++++++++++++
 tb/tb_alu_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - shared encodings and widths for the ALU pipeline
package alu_pipe_pkg;

  localparam int IN_W  = 5;
  localparam int OUT_W = IN_W + 1;

  typedef enum logic [1:0] {
    MODE_A    = 2'd0,
    MODE_B01  = 2'd1,
    MODE_B11  = 2'd2,
    MODE_RSVD = 2'd3
  } OP_MODE_t;

  typedef enum logic {
    ALU_OFF = 1'b0,
    ALU_ON  = 1'b1
  } ALU_EN_STATE_t;

  typedef enum logic [2:0] {
    A_ADD  = 3'd0,
    A_SUB  = 3'd1,
    A_XOR  = 3'd2,
    A_AND1 = 3'd3,
    A_AND2 = 3'd4,
    A_OR   = 3'd5,
    A_XNOR = 3'd6,
    A_NULL = 3'd7
  } OP_A_t;

  // ADD1/ADD2 add their constant to operand a.
  typedef enum logic [1:0] {
    B01_NAND = 2'd0,
    B01_ADD1 = 2'd1,
    B01_ADD2 = 2'd2,
    B01_NULL = 2'd3
  } OP_B01_t;

  typedef enum logic [1:0] {
    B11_XOR     = 2'd0,
    B11_XNOR    = 2'd1,
    B11_A_SUB_1 = 2'd2,
    B11_B_ADD_2 = 2'd3
  } OP_B11_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/alu_compute.sv
// rtl/alu_compute.sv - combinational result arithmetic for one command
module alu_compute
  import alu_pipe_pkg::*;
#(
  parameter int INPUT_WIDTH  = IN_W,
  parameter int OUTPUT_WIDTH = INPUT_WIDTH + 1
) (
  input  OP_MODE_t                op_mode_i,
  input  logic [2:0]              a_op_i,
  input  logic [1:0]              b_op_i,
  input  logic [INPUT_WIDTH-1:0]  a_i,
  input  logic [INPUT_WIDTH-1:0]  b_i,
  output logic [OUTPUT_WIDTH-1:0] result_o,
  output logic                    mode_err_o,
  output logic                    null_o
);

  localparam logic [OUTPUT_WIDTH-1:0] K1 = OUTPUT_WIDTH'(1);
  localparam logic [OUTPUT_WIDTH-1:0] K2 = OUTPUT_WIDTH'(2);

  logic [OUTPUT_WIDTH-1:0] sa, sb, za, zb;

  // Arithmetic uses sign-extended operands, logic ops zero-extended ones.
  assign sa = {a_i[INPUT_WIDTH-1], a_i};
  assign sb = {b_i[INPUT_WIDTH-1], b_i};
  assign za = {1'b0, a_i};
  assign zb = {1'b0, b_i};

  always_comb begin
    result_o   = '0;
    mode_err_o = 1'b0;
    null_o     = 1'b0;
    case (op_mode_i)
      MODE_A: begin
        case (OP_A_t'(a_op_i))
          A_ADD:          result_o = sa + sb;
          A_SUB:          result_o = sa - sb;
          A_XOR:          result_o = za ^ zb;
          A_AND1, A_AND2: result_o = za & zb;
          A_OR:           result_o = za | zb;
          A_XNOR:         result_o = ~(za ^ zb);
          default:        null_o   = 1'b1;
        endcase
      end
      MODE_B01: begin
        case (OP_B01_t'(b_op_i))
          B01_NAND: result_o = ~(za & zb);
          B01_ADD1: result_o = sa + K1;
          B01_ADD2: result_o = sa + K2;
          default:  null_o   = 1'b1;
        endcase
      end
      MODE_B11: begin
        case (OP_B11_t'(b_op_i))
          B11_XOR:     result_o = za ^ zb;
          B11_XNOR:    result_o = ~(za ^ zb);
          B11_A_SUB_1: result_o = sa - K1;
          default:     result_o = sb + K2;
        endcase
      end
      default: mode_err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - ALU with registered command handshake and 2-entry result buffer
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int INPUT_WIDTH  = IN_W,
  parameter int OUTPUT_WIDTH = OUT_W
) (
  input  logic                           clk,
  input  logic                           rst_an,
  input  logic                           alu_en,
  input  logic [1:0]                     op_mode,
  input  logic [2:0]                     a_op,
  input  logic [1:0]                     b_op,
  input  logic signed [INPUT_WIDTH-1:0]  a,
  input  logic signed [INPUT_WIDTH-1:0]  b,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [OUTPUT_WIDTH-1:0] result,
  output logic                           mode_err,
  output logic [7:0]                     null_cnt
);

  buf_state_t              state_q;
  logic                    in_ready_q, out_valid_q;
  logic [OUTPUT_WIDTH-1:0] res0_q, res1_q, last_result_q;
  logic                    err0_q, err1_q;
  logic [7:0]              null_cnt_q;

  logic [OUTPUT_WIDTH-1:0] calc_res;
  logic                    calc_err, calc_null;
  logic [OUTPUT_WIDTH-1:0] entry_res_d;
  logic                    entry_err_d;
  logic                    alu_on, accept, pop;

  alu_compute #(
    .INPUT_WIDTH  (INPUT_WIDTH),
    .OUTPUT_WIDTH (OUTPUT_WIDTH)
  ) u_compute (
    .op_mode_i  (OP_MODE_t'(op_mode)),
    .a_op_i     (a_op),
    .b_op_i     (b_op),
    .a_i        (a),
    .b_i        (b),
    .result_o   (calc_res),
    .mode_err_o (calc_err),
    .null_o     (calc_null)
  );

  assign alu_on      = (ALU_EN_STATE_t'(alu_en) == ALU_ON);
  assign accept      = in_valid && in_ready_q;
  assign pop         = out_valid_q && out_ready;
  // A disabled ALU replays the last enabled result instead of computing.
  assign entry_res_d = alu_on ? calc_res : last_result_q;
  assign entry_err_d = calc_err;

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q       <= ST_EMPTY;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      res0_q        <= '0;
      res1_q        <= '0;
      err0_q        <= 1'b0;
      err1_q        <= 1'b0;
      last_result_q <= '0;
      null_cnt_q    <= '0;
    end else begin
      if (accept && alu_on) begin
        last_result_q <= calc_res;
        if (calc_null && (null_cnt_q != 8'hFF)) null_cnt_q <= null_cnt_q + 8'd1;
      end
      in_ready_q <= 1'b1;
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            res0_q      <= entry_res_d;
            err0_q      <= entry_err_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            res0_q <= entry_res_d;
            err0_q <= entry_err_d;
          end else if (accept) begin
            res1_q     <= entry_res_d;
            err1_q     <= entry_err_d;
            in_ready_q <= 1'b0;
            state_q    <= ST_FULL;
          end else if (pop) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            res0_q  <= res1_q;
            err0_q  <= err1_q;
            state_q <= ST_ONE;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ST_EMPTY;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = signed'(res0_q);
  assign mode_err  = err0_q;
  assign null_cnt  = null_cnt_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_an = 1'b1;
  logic                    alu_en = 1'b1;
  logic [1:0]              op_mode = '0;
  logic [2:0]              a_op = '0;
  logic [1:0]              b_op = '0;
  logic [IN_W-1:0]         a = '0, b = '0;
  logic                    in_valid = 1'b0, out_ready = 1'b1;
  logic                    in_ready, out_valid, mode_err;
  logic signed [OUT_W-1:0] result;
  logic [7:0]              null_cnt;

  int checks = 0;
  int failures = 0;

  alu_pipe #(.INPUT_WIDTH(IN_W), .OUTPUT_WIDTH(OUT_W)) dut (
    .clk(clk), .rst_an(rst_an), .alu_en(alu_en), .op_mode(op_mode),
    .a_op(a_op), .b_op(b_op), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .mode_err(mode_err), .null_cnt(null_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int to_s6(input int v);
    int t;
    t = v & 63;
    return (t >= 32) ? t - 64 : t;
  endfunction

  function automatic int model_op(input OP_MODE_t m, input logic [2:0] ao, input logic [1:0] bo,
                                  input int av, input int bv, output bit err, output bit is_null);
    int ua, ub, r;
    ua = av & 31; ub = bv & 31; r = 0; err = 0; is_null = 0;
    case (m)
      MODE_A:
        case (OP_A_t'(ao))
          A_ADD:          r = av + bv;
          A_SUB:          r = av - bv;
          A_XOR:          r = ua ^ ub;
          A_AND1, A_AND2: r = ua & ub;
          A_OR:           r = ua | ub;
          A_XNOR:         r = ~(ua ^ ub);
          default:        is_null = 1;
        endcase
      MODE_B01:
        case (OP_B01_t'(bo))
          B01_NAND: r = ~(ua & ub);
          B01_ADD1: r = av + 1;
          B01_ADD2: r = av + 2;
          default:  is_null = 1;
        endcase
      MODE_B11:
        case (OP_B11_t'(bo))
          B11_XOR:     r = ua ^ ub;
          B11_XNOR:    r = ~(ua ^ ub);
          B11_A_SUB_1: r = av - 1;
          default:     r = bv + 2;
        endcase
      default: err = 1;
    endcase
    return to_s6(r);
  endfunction

  typedef struct {int res; bit err;} exp_t;
  exp_t mq[$];
  bit   m_ready = 0;
  int   m_null = 0;
  int   m_last = 0;
  bit   m_pop, m_acc, m_err, m_isnull;
  int   m_r;

  always @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      mq.delete();
      m_ready = 0; m_null = 0; m_last = 0;
    end else begin
      m_pop = (mq.size() > 0) && out_ready;
      m_acc = in_valid && m_ready;
      if (m_pop) void'(mq.pop_front());
      if (m_acc) begin
        m_r = model_op(OP_MODE_t'(op_mode), a_op, b_op, int'($signed(a)), int'($signed(b)), m_err, m_isnull);
        if (alu_en) begin
          m_last = m_r;
          if (m_isnull && m_null < 255) m_null++;
        end else begin
          m_r = m_last;
        end
        mq.push_back('{res: m_r, err: m_err});
      end
      m_ready = mq.size() < 2;
    end
  end

  int popped[$];
  always @(negedge clk) begin
    chk("out_valid", int'(out_valid), (mq.size() > 0) ? 1 : 0);
    chk("in_ready", int'(in_ready), int'(m_ready));
    chk("null_cnt", int'(null_cnt), m_null);
    if (mq.size() > 0) begin
      chk("result", int'(result), mq[0].res);
      chk("mode_err", int'(mode_err), int'(mq[0].err));
    end
    if (out_valid && out_ready) popped.push_back(int'(result));
  end

  task automatic drive(input OP_MODE_t m, input logic [2:0] ao, input logic [1:0] bo,
                       input int av, input int bv, input logic en);
    op_mode = m; a_op = ao; b_op = bo; a = av[IN_W-1:0]; b = bv[IN_W-1:0]; alu_en = en;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      failures++;
      $display("FAIL %s: accept timeout, in_ready=%0d, want 1", name, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send(input OP_MODE_t m, input logic [2:0] ao, input logic [1:0] bo,
                      input int av, input int bv, input logic en);
    drive(m, ao, bo, av, bv, en);
    wait_accept("send");
  endtask

  task automatic send_chk(input string name, input OP_MODE_t m, input logic [2:0] ao,
                          input logic [1:0] bo, input int av, input int bv, input logic en,
                          input int exp);
    send(m, ao, bo, av, bv, en);
    @(negedge clk);
    chk({name, "_valid"}, int'(out_valid), 1);
    chk(name, int'(result), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_an = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_mode_err", int'(mode_err), 0);
    chk("rst_null_cnt", int'(null_cnt), 0);
    @(posedge clk);
    #1 rst_an = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", int'(in_ready), 0);
    @(negedge clk);
    chk("ready_after_edge", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Single-cycle latency, one-cycle out_valid pulse
    send(MODE_A, A_ADD, 2'd0, 5, 3, 1'b1);
    @(negedge clk);
    chk("add_latency_valid", int'(out_valid), 1);
    chk("add_5_3", int'(result), 8);
    @(negedge clk);
    chk("add_valid_drops", int'(out_valid), 0);
    @(posedge clk);
    #1;

    send_chk("sub_m16_15", MODE_A, A_SUB, 2'd0, -16, 15, 1'b1, -31);
    send_chk("b11_a_sub_1", MODE_B11, 3'd0, B11_A_SUB_1, -16, 0, 1'b1, -17);
    send_chk("b11_b_add_2", MODE_B11, 3'd0, B11_B_ADD_2, 0, 15, 1'b1, 17);
    send_chk("b01_nand_0", MODE_B01, 3'd0, B01_NAND, 0, 0, 1'b1, -1);
    send_chk("a_xnor_0", MODE_A, A_XNOR, 2'd0, 0, 0, 1'b1, -1);
    send_chk("a_xor_zext", MODE_A, A_XOR, 2'd0, -1, 0, 1'b1, 31);
    send_chk("a_null", MODE_A, A_NULL, 2'd0, 7, 7, 1'b1, 0);
    chk("null_cnt_1", int'(null_cnt), 1);

    send_chk("add_again", MODE_A, A_ADD, 2'd0, 5, 3, 1'b1, 8);
    send_chk("alu_off_hold", MODE_A, A_ADD, 2'd0, 1, 1, 1'b0, 8);
    send(MODE_RSVD, 3'd0, 2'd0, 3, 3, 1'b1);
    @(negedge clk);
    chk("rsvd_result", int'(result), 0);
    chk("rsvd_mode_err", int'(mode_err), 1);
    @(posedge clk);
    #1;
    send_chk("add_2_2", MODE_A, A_ADD, 2'd0, 2, 2, 1'b1, 4);
    send_chk("off_b01_null", MODE_B01, 3'd0, B01_NULL, 0, 0, 1'b0, 4);
    chk("null_cnt_off", int'(null_cnt), 1);
    send_chk("b01_null", MODE_B01, 3'd0, B01_NULL, 0, 0, 1'b1, 0);
    chk("null_cnt_2", int'(null_cnt), 2);

    // Sweep every op with mixed-sign operands; model-checked
    for (int i = 0; i < 8; i++) send(MODE_A, 3'(i), 2'd0, -9, 6, 1'b1);
    for (int i = 0; i < 4; i++) send(MODE_B01, 3'd0, 2'(i), -9, 6, 1'b1);
    for (int i = 0; i < 4; i++) send(MODE_B11, 3'd0, 2'(i), -9, 6, 1'b1);

    // Backpressure: two fill the buffer, third waits
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    popped.delete();
    send(MODE_A, A_ADD, 2'd0, 1, 2, 1'b1);
    send(MODE_A, A_ADD, 2'd0, 3, 4, 1'b1);
    drive(MODE_A, A_XOR, 2'd0, 12, 10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready", int'(in_ready), 0);
      chk("full_head_stable", int'(result), 3);
      chk("full_out_valid", int'(out_valid), 1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_accept("third");
    repeat (4) @(negedge clk);
    chk("order_count", popped.size(), 3);
    if (popped.size() == 3) begin
      chk("order_0", popped[0], 3);
      chk("order_1", popped[1], 7);
      chk("order_2", popped[2], 6);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 256; i++) send(MODE_A, A_NULL, 2'd0, 0, 0, 1'b1);
    @(negedge clk);
    chk("null_cnt_sat", int'(null_cnt), 255);
    @(posedge clk);
    #1;

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    send(MODE_A, A_ADD, 2'd0, 2, 3, 1'b1);
    send(MODE_A, A_ADD, 2'd0, 4, 5, 1'b1);
    #2 rst_an = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_null_cnt", int'(null_cnt), 0);
    chk("arst_in_ready", int'(in_ready), 0);
    chk("arst_result", int'(result), 0);
    @(posedge clk);
    #1 rst_an = 1'b1;
    out_ready = 1'b1;
    popped.delete();
    send(MODE_A, A_ADD, 2'd0, -7, -8, 1'b1);
    repeat (3) @(negedge clk);
    chk("post_rst_count", popped.size(), 1);
    if (popped.size() == 1) chk("post_rst_add", popped[0], -15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
